// File: rtl/alu_logic_arbiter.sv
// Two-requester round-robin front end for a shared 16-bit bitwise logic unit.
// One operation in flight at a time: IDLE (arbitrate/capture) -> EXEC (compute) -> DONE (hold result).
module alu_logic_arbiter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic             res_zero,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_NOR = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q, res_id_d;
  logic             res_zero_q, res_zero_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic             grant0_c, grant1_c;
  logic [WIDTH-1:0] func_c;

  // Round-robin: on a tie the requester that did not win last time is granted.
  always_comb begin
    grant0_c = req0_valid && (!req1_valid || last_grant_q);
    grant1_c = req1_valid && (!req0_valid || !last_grant_q);
  end

  // Readies are forced low while reset is asserted so nothing looks accepted.
  assign req0_ready = rst_n && (state_q == IDLE) && grant0_c;
  assign req1_ready = rst_n && (state_q == IDLE) && grant1_c;
  assign busy       = (state_q != IDLE);

  always_comb begin
    func_c = '0;
    case (op_q)
      OP_OR:   func_c = a_q | b_q;
      OP_NOR:  func_c = ~(a_q | b_q);
      OP_AND:  func_c = a_q & b_q;
      OP_XOR:  func_c = a_q ^ b_q;
      default: func_c = '0;
    endcase
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_id_d     = res_id_q;
    res_zero_d   = res_zero_q;
    op_count_d   = op_count_q;

    case (state_q)
      IDLE: begin
        if (req0_ready) begin
          a_d          = req0_a;
          b_d          = req0_b;
          op_d         = req0_op;
          id_d         = 1'b0;
          last_grant_d = 1'b0;
          state_d      = EXEC;
        end else if (req1_ready) begin
          a_d          = req1_a;
          b_d          = req1_b;
          op_d         = req1_op;
          id_d         = 1'b1;
          last_grant_d = 1'b1;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = func_c;
        res_zero_d  = (func_c == '0);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          op_count_d  = op_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_id_q     <= 1'b0;
      res_zero_q   <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_id_q     <= res_id_d;
      res_zero_q   <= res_zero_d;
      op_count_q   <= op_count_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;
  assign res_zero  = res_zero_q;
  assign op_count  = op_count_q;

endmodule
